// File: rtl/moore_modn_reg_next_out.sv
// Modulo-MODULUS up/down Moore pulse counter with clear, clamped load
// and a wrap pulse; every output is registered from the next state.
module moore_modn_reg_next_out #(
    parameter int MODULUS = 3,
    parameter int W = (MODULUS > 2) ? $clog2(MODULUS) : 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         enable,
    input  logic         a,
    input  logic         dir,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] count,
    output logic         y,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(MODULUS - 1);
    localparam logic [W-1:0] ONE  = W'(1);

    logic [W-1:0] state_q, state_d;
    logic [W-1:0] count_q;
    logic         y_q;
    logic         wrap_q, wrap_d;
    logic         step;
    logic         illegal;
    logic [W-1:0] load_clamped;

    assign step         = enable & a;
    assign illegal      = (state_q > LAST);
    assign load_clamped = (load_value > LAST) ? LAST : load_value;

    // State register; count/y/wrap share the edge with the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= '0;
            count_q <= '0;
            y_q     <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= state_d;
            y_q     <= (state_d != '0);
            wrap_q  <= wrap_d;
        end
    end

    // Next state: recovery > clear > load > step > hold.
    always_comb begin
        state_d = state_q;
        wrap_d  = 1'b0;
        if (illegal) begin
            state_d = '0;
        end else if (clear) begin
            state_d = '0;
        end else if (load) begin
            state_d = load_clamped;
        end else if (step) begin
            if (!dir) begin
                if (state_q == LAST) begin
                    state_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    state_d = state_q + ONE;
                end
            end else begin
                if (state_q == '0) begin
                    state_d = LAST;
                    wrap_d  = 1'b1;
                end else begin
                    state_d = state_q - ONE;
                end
            end
        end
    end

    always_comb begin
        count = count_q;
        y     = y_q;
        wrap  = wrap_q;
    end

endmodule

// File: doc/moore_modn_reg_next_out.md
Name: moore_modn_reg_next_out

Overview:
- Parametrised generalisation of the team's 3-state Moore pulse counter with registered outputs.
- The FSM counts qualified input pulses modulo MODULUS. It can count up or down, and supports synchronous clear, parallel load and a wrap indication.
- Every output is registered from the next-state value, so outputs change on the same edge as the state register and carry no extra latency.
- Sits in the lab FSM set as a reusable event divider / sequencer front end.

Parameters:
- MODULUS, 3, number of states (must be >= 2); state encoding is binary 0..MODULUS-1.
- W, $clog2(MODULUS) (minimum 1), width of the state and count vector.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  qualifies a; when 0, counting steps are ignored.
- a  input  1  count event; one step per cycle while enable=1 and a=1.
- dir  input  1  step direction: 0 = up, 1 = down; sampled only on a step cycle.
- clear  input  1  synchronous clear of the state to 0; independent of enable.
- load  input  1  synchronous parallel load; independent of enable.
- load_value  input  W  value written by load.
- count  output  W  registered copy of the state.
- y  output  1  registered, 1 when the state is nonzero (matches the legacy y definition).
- wrap  output  1  one-cycle registered pulse on a modular wrap.

Behaviour:
- Reset: when reset=1 at a rising edge, then state=0, count=0, y=0, wrap=0. Reset takes priority over all other inputs. Asserting reset mid-count discards the count on that edge.
- Per-edge priority: reset > clear > load > step (enable & a) > hold.
- Clear:
  - next=0, wrap=0.
  - Clear overrides a simultaneous load or step, and clear on the wrap cycle suppresses wrap.
- Load:
  - next = load_value, but values >= MODULUS are clamped to MODULUS-1.
  - wrap=0; a simultaneous step is discarded.
- Step, up (dir=0): if state == MODULUS-1, next=0 and wrap=1; otherwise next = state+1 and wrap=0.
- Step, down (dir=1): if state == 0, next = MODULUS-1 and wrap=1; otherwise next = state-1 and wrap=0.
- Hold (none of the above): next = state, wrap=0; count and y are unchanged.
- Output registers:
  - count <= next and y <= (next != 0) on every edge, computed from the same next value.
  - Invariants: count == state and y == (state != 0) on every cycle after reset.
- wrap is high for exactly one cycle per wrap event, so back-to-back wraps give back-to-back pulses.
  - A MODULUS=2 up-count with a held high wraps every second cycle.
- Illegal state encodings (state >= MODULUS, possible only when MODULUS is not a power of two): next=0 on the next edge regardless of inputs except reset; wrap=0.
- No combinational path from any input to any output.
- Latency: an input sampled at edge k is reflected in count, y and wrap immediately after edge k.

Test Plan:
- MODULUS=3, reset, then enable=1, a=1, dir=0 for 7 cycles → count 1,2,0,1,2,0,1; y 1,1,0,1,1,0,1; wrap high only after the 3rd and 6th edges.
- MODULUS=3, enable=0, a=1 for 4 cycles from count=2 → count stays 2, y=1, wrap=0 throughout; then enable=1 for one cycle → count=0, y=0, wrap=1.
- MODULUS=5, dir=1 from reset with enable=a=1 for 6 cycles → count 4,3,2,1,0,4; wrap pulses after the 1st and 6th edges.
- MODULUS=5 at count=4, up-step and load=1 with load_value=7 on the same edge → count=4 (clamped), wrap=0. Then clear=1 and load=1 with a step → count=0, y=0, wrap=0.
- MODULUS=6, count=3, reset=1 for one edge while enable=a=1 → count=0, y=0, wrap=0; counting resumes from 1 on the next step.
- MODULUS=2, enable=a=1 for 4 cycles → count 1,0,1,0; wrap 0,1,0,1; y 1,0,1,0.
